hv_sign_packer: RTL and testbench
=================================

HV_SIGN_PACKER -- requirements
Module: hv_sign_packer

Interface
REQ-001 Parameter DIM, default 1024: number of accumulator sign bits consumed; SHALL be a multiple of WORD.
REQ-002 Parameter WORD, default 32: output word width in bits.
REQ-003 Parameter SETTLE, default 2: cycles from start to snapshot (covers the accumulator pipeline depth); SHALL be at least 1.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse: accumulation finished, begin readout.
REQ-007 sign_vec  input  DIM  sign bits of the counter bank, bit i from counter i (1 = negative sum).
REQ-008 out_data  output  WORD  packed binary hypervector word.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream (DMA writer) accepts word.
REQ-011 out_last  output  1  high with the final word of a vector.
REQ-012 busy  output  1  high from the start acceptance through the final word transfer.
REQ-013 done  output  1  one-cycle pulse after the final word transfer.

Function
REQ-014 FSM states IDLE, SETTLE, SEND; the reset state SHALL be IDLE.
REQ-015 IDLE: start=1 -> SETTLE, settle counter loaded with SETTLE-1, busy=1 from the next cycle.
REQ-016 SETTLE: the counter SHALL decrement once per cycle; the cycle it reads 0, the block SHALL snapshot sign_vec into an internal DIM-bit register and move to SEND.
REQ-017 Snapshot bit i SHALL equal ~sign_vec[i] (1 = non-negative sum, binarized HV convention).
REQ-018 After the snapshot, changes on sign_vec SHALL NOT affect the words emitted for the current vector.
REQ-019 SEND: out_valid=1; out_data = snapshot[k*WORD +: WORD] for word index k, k starting at 0.
REQ-020 Transfer occurs on a cycle with out_valid && out_ready; k SHALL increment by 1 per transfer.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_last and k SHALL hold stable.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready.
REQ-023 out_last SHALL be 1 iff k = DIM/WORD-1 while out_valid=1.
REQ-024 Transfer with out_last=1 -> IDLE next cycle, k cleared to 0, busy=0, done=1 for exactly that one cycle.
REQ-025 start while busy=1 (SETTLE or SEND) SHALL be ignored; no queuing, no restart.
REQ-026 start in the same cycle that done=1 (state already IDLE) SHALL be accepted normally.
REQ-027 Word-index counter width SHALL be max(1, clog2(DIM/WORD)); it SHALL never exceed DIM/WORD-1.
REQ-028 With DIM=WORD, a single word SHALL be emitted with out_last=1.
REQ-029 Back-to-back out_ready=1 SHALL sustain one word per cycle; minimum latency from start to the first out_valid SHALL be SETTLE+1 cycles.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, out_valid=0, out_last=0, busy=0, done=0, k=0, out_data=0, and settle counter=0; the snapshot is don't-care.
REQ-031 rst asserted mid-SETTLE or mid-SEND SHALL abandon the vector; after release, no word SHALL be emitted until a new start.
REQ-032 rst released with start=1 on the first active edge SHALL be accepted.

Verification (bench DIM=64, WORD=32, SETTLE=2)
REQ-033 Assert sign_vec=64'h0000_0000_FFFF_FFFF and start, with out_ready=1 -> out_valid rises on cycle 3; words are 32'h0000_0000 then 32'hFFFF_FFFF, out_last on the 2nd word, done one cycle later.
REQ-034 Change sign_vec to all-ones one cycle after the snapshot, with out_ready=0 for 5 cycles -> out_data held at the snapshot word 0 throughout, and the emitted words are unaffected by the change.
REQ-035 Apply a second start pulse during SEND -> ignored; exactly 2 words and 1 done pulse are produced.
REQ-036 Assert rst=0 during SEND after word 0 is transferred -> outputs zero asynchronously; after release with no start, out_valid stays 0 for 20 cycles.
REQ-037 Issue start in the done cycle, with random out_ready (50%) -> the second vector is emitted complete and in order, with no lost or duplicated words.

Source files
------------

// File: rtl/hv_sign_packer_if.sv
// Word stream from the sign packer to the DMA writer: valid/ready handshake with an end-of-vector marker.
interface hv_sign_packer_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/hv_sign_packer.sv
// Snapshots inverted counter signs SETTLE cycles after start, then streams them as WORD-bit words; first word SETTLE+1 cycles after start.
// All outputs registered; the current word holds while out_ready is low and one word per cycle flows when it is high.
module hv_sign_packer #(
    parameter int DIM    = 1024,
    parameter int WORD   = 32,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM-1:0]     sign_vec,
    hv_sign_packer_if.master   out_if,
    output logic               busy,
    output logic               done
);
    localparam int NW = DIM / WORD;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);
    localparam logic [SW-1:0] S_LOAD = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SEND
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   settle_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [DIM-1:0]  snap_q;
    logic [DIM-1:0]  snap_d;
    logic [WORD-1:0] data_q;
    logic            vld_q;
    logic            last_q;
    logic            busy_q;
    logic            done_q;
    logic            xfer;
    logic            snap_en;

    // Binarized HV convention: a set bit means the counter sum is non-negative.
    assign snap_d  = ~sign_vec;
    assign snap_en = (state_q == ST_SETTLE) && (settle_q == '0);
    assign xfer    = vld_q && out_if.out_ready;

    always_comb begin
        k_d = k_q + KW'(1);
    end

    // Contents are meaningless until loaded, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            snap_q <= snap_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            k_q      <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_SETTLE;
                        settle_q <= S_LOAD;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        // Word 0 comes straight from the live vector so it is valid on the next cycle.
                        state_q <= ST_SEND;
                        vld_q   <= 1'b1;
                        data_q  <= snap_d[WORD-1:0];
                        last_q  <= (K_LAST == '0);
                        k_q     <= '0;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                            vld_q   <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            k_q     <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            k_q    <= k_d;
                            data_q <= snap_q[k_d*WORD +: WORD];
                            last_q <= (k_d == K_LAST);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = vld_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_hv_sign_packer.sv
// Scoreboard bench for hv_sign_packer at DIM=64, WORD=32, SETTLE=2.
module tb_hv_sign_packer;
    localparam int DIM    = 64;
    localparam int WORD   = 32;
    localparam int SETTLE = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [DIM-1:0]  sign_vec = '0;
    logic            busy;
    logic            done;

    hv_sign_packer_if #(.WORD(WORD)) hv_if ();

    hv_sign_packer #(
        .DIM    (DIM),
        .WORD   (WORD),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign_vec (sign_vec),
        .out_if   (hv_if),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_words = 0;
    logic [32:0] sb_q[$];
    bit          rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_vec(input logic [63:0] sv);
        sb_q.push_back({1'b0, ~sv[31:0]});
        sb_q.push_back({1'b1, ~sv[63:32]});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sb_q.size() != 0 || busy); i++) @(negedge clk);
        chk("drain_left", 64'(sb_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        tick();
    endtask

    // Scoreboard consumer: every accepted word must be the next expected one.
    always @(negedge clk) begin
        logic [32:0] exp_w;
        if (rst && hv_if.out_valid && hv_if.out_ready) begin
            n_words++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                exp_w = sb_q.pop_front();
                chk("word", 64'({hv_if.out_last, hv_if.out_data}), 64'(exp_w));
            end
        end
        if (rst && done) n_done++;
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #2;
            hv_if.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pv;
        int          w0;
        int          d0;
        hv_if.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_vld",  64'(hv_if.out_valid), 64'd0);
        chk("rst_last", 64'(hv_if.out_last), 64'd0);
        chk("rst_data", 64'(hv_if.out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        tick();

        // Basic vector: latency, word order, last and done timing
        hv_if.out_ready = 1'b1;
        sign_vec = 64'h0000_0000_FFFF_FFFF;
        start = 1'b1;
        push_vec(sign_vec);
        @(negedge clk);
        chk("t1_vld_c0", 64'(hv_if.out_valid), 64'd0);
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("t1_vld_c1", 64'(hv_if.out_valid), 64'd0);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_vld_c2", 64'(hv_if.out_valid), 64'd0);
        @(negedge clk);
        chk("t1_vld_c3", 64'(hv_if.out_valid), 64'd1);
        @(negedge clk);
        chk("t1_last_c4", 64'(hv_if.out_last), 64'd1);
        @(negedge clk);
        chk("t1_done_c5", 64'(done), 64'd1);
        chk("t1_busy_c5", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t1_done_c6", 64'(done), 64'd0);
        tick();

        // Snapshot isolation and hold under backpressure
        hv_if.out_ready = 1'b0;
        pv = 64'h1234_5678_9ABC_DEF0;
        sign_vec = pv;
        start = 1'b1;
        push_vec(pv);
        tick();
        start = 1'b0;
        tick();
        tick();
        sign_vec = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t2_hold", 64'({hv_if.out_valid, hv_if.out_data}), 64'({1'b1, ~pv[31:0]}));
        end
        @(posedge clk); #2;
        hv_if.out_ready = 1'b1;
        drain(20);

        // Starts during SETTLE and SEND are ignored
        w0 = n_words;
        d0 = n_done;
        pv = 64'hA5A5_0F0F_3C3C_F00D;
        sign_vec = pv;
        start = 1'b1;
        push_vec(pv);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(20);
        repeat (10) tick();
        chk("t3_words", 64'(n_words - w0), 64'd2);
        chk("t3_dones", 64'(n_done - d0), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-SEND abandons the vector
        hv_if.out_ready = 1'b0;
        sign_vec = '0;
        start = 1'b1;
        push_vec(sign_vec);
        tick();
        start = 1'b0;
        tick();
        tick();
        hv_if.out_ready = 1'b1;
        tick();
        hv_if.out_ready = 1'b0;
        rst = 1'b0;
        sb_q.delete();
        #1;
        chk("t4_rst_vld",  64'(hv_if.out_valid), 64'd0);
        chk("t4_rst_data", 64'(hv_if.out_data), 64'd0);
        chk("t4_rst_last", 64'(hv_if.out_last), 64'd0);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        hv_if.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t4_idle_vld", 64'(hv_if.out_valid), 64'd0);
        end
        tick();

        // Start present on the first edge after reset release
        rst = 1'b0;
        tick();
        pv = 64'h0123_4567_89AB_CDEF;
        sign_vec = pv;
        start = 1'b1;
        push_vec(pv);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        drain(20);

        // Restart in the done cycle with random backpressure
        d0 = n_done;
        rnd_rdy = 1'b1;
        pv = 64'hDEAD_BEEF_0BAD_F00D;
        sign_vec = pv;
        start = 1'b1;
        push_vec(pv);
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        chk("t6_done_seen", 64'(done), 64'd1);
        pv = 64'h7777_1234_CAFE_0001;
        sign_vec = pv;
        start = 1'b1;
        push_vec(pv);
        @(posedge clk); #2;
        start = 1'b0;
        drain(400);
        rnd_rdy = 1'b0;
        chk("t6_dones", 64'(n_done - d0), 64'd2);

        chk("sb_empty_end", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
